// File: rtl/sat_alu_pkg.sv
// rtl/sat_alu_pkg.sv - shared definitions for the saturating add/sub pipeline
//
// Purpose: operation encoding for the mode port and bit positions inside
//          the {Z, V, N} flags vector.
// Ports:   none (package).
package sat_alu_pkg;

   localparam logic [1:0] MODE_ADD  = 2'b00;
   localparam logic [1:0] MODE_SUB  = 2'b01;
   localparam logic [1:0] MODE_PADD = 2'b10;
   // 2'b11 is decoded as ADD by the datapath.

   localparam int FLAG_N = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_W = 3;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational signed saturating adder
//
// Purpose: sum = sat(a + b + cin) for W-bit two's complement operands.
// Ports:   a, b  [W-1:0] operands
//          cin           carry in (used to form a - b as a + ~b + 1)
//          sum   [W-1:0] saturated sum
//          ovf           signed overflow occurred before saturation
module sat_add
   import sat_alu_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W:0] ext;

   // One guard bit: the true sum fits in W+1 bits, so a disagreement
   // between the guard bit and the W-bit sign marks overflow, and the
   // guard bit gives the true sign for choosing the clamp direction.
   assign ext = {a[W-1], a} + {b[W-1], b} + {{W{1'b0}}, cin};
   assign ovf = ext[W] ^ ext[W-1];

   always_comb begin
      sum = ext[W-1:0];
      if (ovf) begin
         sum = ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/sat_addsub_pipe.sv
// rtl/sat_addsub_pipe.sv - two-stage saturating add/sub/packed-add pipeline
//
// Purpose: S1 captures operands and mode, S2 captures the saturated result
//          and flags. Valid/ready handshake on both sides, one op per cycle.
// Optional: SAT_ADDSUB_STICKY_OVF_EN enables the sticky overflow bit;
//           without it sticky_ovf is 0 and ovf_clr is ignored.
// Ports:   clk, rst_n            clock, async active-low reset
//          in_valid/in_ready     operand handshake (a, b, mode)
//          out_valid/out_ready   result handshake (result, flags)
//          flags [2:0]           {Z, V, N}
//          ovf_clr, sticky_ovf   sticky overflow clear / indicator
module sat_addsub_pipe
   import sat_alu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int LANE_W = 4   // WIDTH must be a multiple of LANE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flags,
   input  logic             ovf_clr,
   output logic             sticky_ovf
);

   localparam int LANES = WIDTH / LANE_W;

   logic             s1_full;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [1:0]       s1_mode;

   logic             s2_adv;
   logic             s1_adv;

   logic [WIDTH-1:0] full_b;
   logic             full_cin;
   logic [WIDTH-1:0] full_sum;
   logic             full_ovf;
   logic [WIDTH-1:0] lane_sum;
   logic [LANES-1:0] lane_ovf;

   logic [WIDTH-1:0] res_c;
   logic [2:0]       flags_c;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = s1_full && s2_adv;
   assign in_ready = !s1_full || s1_adv;

   // SUB reuses the adder as a + ~b + 1.
   assign full_cin = (s1_mode == MODE_SUB);
   assign full_b   = full_cin ? ~s1_b : s1_b;

   sat_add #(.W(WIDTH)) u_full (
      .a   (s1_a),
      .b   (full_b),
      .cin (full_cin),
      .sum (full_sum),
      .ovf (full_ovf)
   );

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sat_add #(.W(LANE_W)) u_lane (
         .a   (s1_a[i*LANE_W +: LANE_W]),
         .b   (s1_b[i*LANE_W +: LANE_W]),
         .cin (1'b0),
         .sum (lane_sum[i*LANE_W +: LANE_W]),
         .ovf (lane_ovf[i])
      );
   end

   always_comb begin
      res_c   = full_sum;
      flags_c = '0;
      flags_c[FLAG_V] = full_ovf;
      if (s1_mode == MODE_PADD) begin
         res_c           = lane_sum;
         flags_c[FLAG_V] = |lane_ovf;
      end
      flags_c[FLAG_Z] = (res_c == '0);
      flags_c[FLAG_N] = res_c[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_full <= 1'b0;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_mode <= MODE_ADD;
      end else if (in_ready) begin
         s1_full <= in_valid;
         if (in_valid) begin
            s1_a    <= a;
            s1_b    <= b;
            s1_mode <= mode;
         end
      end
   end

   // Result and flags only change when a new op lands, so they stay put
   // both under back-pressure and after the consumer drains the stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_full;
         if (s1_full) begin
            result <= res_c;
            flags  <= flags_c;
         end
      end
   end

`ifdef SAT_ADDSUB_STICKY_OVF_EN
   // Set wins over clear so an overflow in the clearing cycle is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_ovf <= 1'b0;
      end else if (s1_adv && flags_c[FLAG_V]) begin
         sticky_ovf <= 1'b1;
      end else if (ovf_clr) begin
         sticky_ovf <= 1'b0;
      end
   end
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign sticky_ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// tb/tb_sat_addsub_pipe.sv - self-checking bench for sat_addsub_pipe
module tb_sat_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [1:0]  mode = 2'b00;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] result;
   logic [2:0]  flags;
   logic        ovf_clr = 1'b0;
   logic        sticky_ovf;

   int total = 0;
   int bad   = 0;
   logic [18:0] sb_q[$];

   always #5 clk = ~clk;

   sat_addsub_pipe #(.WIDTH(16), .LANE_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .mode       (mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .flags      (flags),
      .ovf_clr    (ovf_clr),
      .sticky_ovf (sticky_ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: saturate the mathematically exact signed sum.
   function automatic logic [18:0] ref_op(input logic [15:0] x, input logic [15:0] y, input logic [1:0] m);
      logic [15:0] r;
      logic [3:0]  xl, yl;
      bit          v;
      int          s;
      v = 0;
      r = '0;
      if (m == 2'b10) begin
         for (int i = 0; i < 4; i++) begin
            xl = x[i*4 +: 4];
            yl = y[i*4 +: 4];
            s  = int'($signed(xl)) + int'($signed(yl));
            if (s > 7) begin
               s = 7;  v = 1;
            end else if (s < -8) begin
               s = -8; v = 1;
            end
            r[i*4 +: 4] = s[3:0];
         end
      end else begin
         if (m == 2'b01) s = int'($signed(x)) - int'($signed(y));
         else            s = int'($signed(x)) + int'($signed(y));
         if (s > 32767) begin
            s = 32767;  v = 1;
         end else if (s < -32768) begin
            s = -32768; v = 1;
         end
         r = s[15:0];
      end
      return {(r == 16'h0), v, r[15], r};
   endfunction

   // Scoreboard: transfers are observed on the negedge preceding their edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
               logic [18:0] e;
               e = sb_q.pop_front();
               check("sb_result", {16'd0, result}, {16'd0, e[15:0]});
               check("sb_flags", {29'd0, flags}, {29'd0, e[18:16]});
            end
         end
         if (in_valid && in_ready) sb_q.push_back(ref_op(a, b, mode));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [1:0] m);
      bit ok;
      ok = 0;
      in_valid = 1'b1; a = x; b = y; mode = m;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1;
         tick();
      end
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] r, input logic [2:0] f);
      bit ok;
      ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (out_valid) ok = 1;
         else tick();
      end
      check({tag, "_seen"}, {31'd0, ok}, 32'd1);
      check({tag, "_res"}, {16'd0, result}, {16'd0, r});
      check({tag, "_flg"}, {29'd0, flags}, {29'd0, f});
      tick();
   endtask

   initial begin
      logic [15:0] held;
      int          seen;
      bit          ok;

      // Reset state
      #2;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", {16'd0, result}, 32'd0);
      check("rst_flags", {29'd0, flags}, 32'd0);
      check("rst_sticky", {31'd0, sticky_ovf}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Latency: ADD 0x7FFF + 1 saturates; visible two edges after acceptance
      in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; mode = 2'b00;
      @(negedge clk);
      check("lat_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check("lat_cycle1", {31'd0, out_valid}, 32'd0);
      tick();
      check("lat_cycle2", {31'd0, out_valid}, 32'd1);
      check("add_sat_res", {16'd0, result}, 32'h7FFF);
      check("add_sat_flg", {29'd0, flags}, 32'b010);
      tick();

      // Directed arithmetic cases
      send(16'h8000, 16'h0001, 2'b01);
      expect_out("sub_neg_sat", 16'h8000, 3'b011);
      send(16'h1234, 16'h1234, 2'b01);
      expect_out("sub_zero", 16'h0000, 3'b100);
      send(16'h7878, 16'h1111, 2'b10);
      expect_out("padd_ovf", 16'h7979, 3'b010);
      send(16'h1234, 16'h1111, 2'b10);
      expect_out("padd_clean", 16'h2345, 3'b000);
      send(16'h7FFF, 16'h0001, 2'b11);
      expect_out("mode3_add", 16'h7FFF, 3'b010);
      send(16'h0000, 16'h8000, 2'b01);
      expect_out("sub_min", 16'h7FFF, 3'b010);

      // Sticky overflow
`ifdef SAT_ADDSUB_STICKY_OVF_EN
      send(16'h7FFF, 16'h0001, 2'b00);
      tick();
      check("sticky_set", {31'd0, sticky_ovf}, 32'd1);
      send(16'h0001, 16'h0001, 2'b00);
      tick(); tick();
      check("sticky_hold", {31'd0, sticky_ovf}, 32'd1);
      send(16'h8000, 16'h0001, 2'b01);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("sticky_set_wins", {31'd0, sticky_ovf}, 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("sticky_clear", {31'd0, sticky_ovf}, 32'd0);
`else
      send(16'h7FFF, 16'h0001, 2'b00);
      tick(); tick();
      check("sticky_off", {31'd0, sticky_ovf}, 32'd0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("sticky_off_clr", {31'd0, sticky_ovf}, 32'd0);
`endif
      tick(); tick();

      // Back-pressure: three ops with out_ready low
      out_ready = 1'b0;
      in_valid = 1'b1; a = 16'h0100; b = 16'h0001; mode = 2'b00;
      @(negedge clk);
      check("bp_rdy0", {31'd0, in_ready}, 32'd1);
      tick();
      a = 16'h0200; b = 16'h0002; mode = 2'b01;
      @(negedge clk);
      check("bp_rdy1", {31'd0, in_ready}, 32'd1);
      tick();
      a = 16'h6000; b = 16'h3000; mode = 2'b00;
      @(negedge clk);
      check("bp_rdy2", {31'd0, in_ready}, 32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      held = result;
      tick(); tick(); tick();
      @(negedge clk);
      check("bp_stall_rdy", {31'd0, in_ready}, 32'd0);
      check("bp_hold", {16'd0, result}, {16'd0, held});
      check("bp_first", {16'd0, result}, 32'h0101);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_out0", {31'd0, out_valid}, 32'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_out1", {31'd0, out_valid}, 32'd1);
      check("bp_res1", {16'd0, result}, 32'h01FE);
      tick();
      @(negedge clk);
      check("bp_out2", {31'd0, out_valid}, 32'd1);
      check("bp_res2", {16'd0, result}, 32'h7FFF);
      tick();
      tick();

      // Reset with both stages full
      out_ready = 1'b0;
      send(16'h0003, 16'h0004, 2'b00);
      send(16'h0005, 16'h0006, 2'b00);
      @(negedge clk);
      check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      check("pre_rst_full", {31'd0, in_ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, out_valid}, 32'd0);
      check("arst_ready", {31'd0, in_ready}, 32'd1);
      check("arst_result", {16'd0, result}, 32'd0);
      check("arst_flags", {29'd0, flags}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
         tick();
      end
      check("no_stale", seen, 32'd0);

      // Randomized traffic with random back-pressure
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         mode      = 2'($urandom_range(3));
         case ($urandom_range(3))
            0: begin a = 16'h7FFF - 16'($urandom_range(3)); b = 16'($urandom_range(7)); end
            1: begin a = 16'h8000 + 16'($urandom_range(3)); b = 16'h8000 + 16'($urandom_range(7)); end
            default: begin a = 16'($urandom); b = 16'($urandom); end
         endcase
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         if (sb_q.size() == 0 && !out_valid) ok = 1;
      end
      check("drain", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
